// File: rtl/instruction_packer_pkg.sv
// instruction_packer_pkg: shared types, opcodes and the RV32I field-packing function.
// Rev 1.0
`default_nettype none

package instruction_packer_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0]  OP_R     = 7'h33;
  localparam logic [6:0]  OP_I     = 7'h13;
  localparam logic [6:0]  OP_S     = 7'h23;
  localparam logic [6:0]  OP_B     = 7'h63;
  localparam logic [6:0]  OP_LUI   = 7'h37;
  localparam logic [6:0]  OP_JAL   = 7'h6F;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic logic fmt_is_legal(input logic [2:0] fmt);
    return fmt <= 3'd5;
  endfunction

  // Illegal formats collapse to the canonical NOP (addi x0,x0,0).
  function automatic logic [31:0] pack_instr(
    input logic [2:0]  fmt,
    input logic [6:0]  op,
    input logic [4:0]  rd,
    input logic [2:0]  f3,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [6:0]  f7,
    input logic [31:0] imm
  );
    logic [31:0] w;
    w = NOP_WORD;
    case (fmt)
      FMT_R:   w = {f7, rs2, rs1, f3, rd, op};
      FMT_I:   w = {imm[11:0], rs1, f3, rd, op};
      FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      FMT_U:   w = {imm[31:12], rd, op};
      FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: w = NOP_WORD;
    endcase
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_packer_if.sv
// instruction_packer_if: field-bundle input stream plus instruction-memory write port.
// Rev 1.0
`default_nettype none

interface instruction_packer_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [2:0]        fmt;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [2:0]        funct3;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_last, fmt, opcode, rd, funct3, rs1, rs2, funct7, imm, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_last, fmt, opcode, rd, funct3, rs1, rs2, funct7, imm, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/instruction_packer_fifo.sv
// instruction_packer_fifo: synchronous FIFO; a push is accepted when full if a pop happens too.
// Rev 1.0
`default_nettype none

module instruction_packer_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  wire logic                       clk,
  input  wire logic                       reset,
  input  wire logic                       i_push,
  input  wire logic [WIDTH-1:0]           i_data,
  input  wire logic                       i_pop,
  output logic      [WIDTH-1:0]           o_data,
  output logic                            o_full,
  output logic                            o_empty,
  output logic      [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: rtl/instruction_packer.sv
// instruction_packer: packs decoded RV32I fields into words and streams them to instruction memory.
// Rev 1.0
`default_nettype none

module instruction_packer
  import instruction_packer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              start,
  input  wire logic [ADDR_W-1:0] base_addr,
  instruction_packer_if.slave    bus,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;

  logic              w_accept;
  logic              w_pop;
  logic              w_active;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [31:0]       w_word;
  logic [31:0]       w_head;

  assign w_active      = (r_state == ST_ACCEPT) || (r_state == ST_DRAIN);
  assign bus.in_ready  = (r_state == ST_ACCEPT) && !w_full;
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign bus.mem_we    = w_active && !w_empty;
  assign w_pop         = bus.mem_we && bus.mem_ready;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = bus.mem_we ? w_head : 32'h0;

  assign w_word = pack_instr(bus.fmt, bus.opcode, bus.rd, bus.funct3,
                             bus.rs1, bus.rs2, bus.funct7, bus.imm);

  instruction_packer_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_accept),
    .i_data  (w_word),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_pop) r_addr <= r_addr + ADDR_W'(4);
      if (w_accept && !fmt_is_legal(bus.fmt)) r_err <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr  <= {base_addr[ADDR_W-1:2], 2'b00};
            r_err   <= 1'b0;
            r_state <= ST_ACCEPT;
          end
        end
        ST_ACCEPT: begin
          if (w_accept && bus.in_last) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Finish only once the last queued word has been handed to memory.
          if (w_empty || (w_pop && (w_count == CNT_W'(1)))) r_state <= ST_DONE;
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = w_active;
  assign done = (r_state == ST_DONE);
  assign err  = r_err;
endmodule

`default_nettype wire
